demux1x2_8bits: RTL and testbench

Lane splitter on the receive side of the 8-bit two-lane link. It takes the single interleaved byte stream produced by the 2:1 lane multiplexer and routes each valid byte back to lane 0 or lane 1 using a free-running lane selector that toggles every clock, matching the transmitter's selector. Each lane has a small FIFO so downstream consumers can pop at their own pace. Overflow is detected and flagged per lane.

---
 rtl/pcie_link_pkg.sv | 10 +
 rtl/demux1x2_8bits_lane_fifo.sv | 79 +++++++
 rtl/demux1x2_8bits.sv | 79 +++++++
 tb/tb_demux1x2_8bits.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_link_pkg.sv
// Shared constants and types for the 8-bit two-lane link.
package pcie_link_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DROP_W    = 8;

  typedef logic [0:0] lane_sel_t;

endpackage

// File: rtl/demux1x2_8bits_lane_fifo.sv
// lane_fifo: one per-lane synchronous FIFO with sticky overflow.
// DEMUX_DROP_CNT_EN adds a saturating count of dropped bytes.
import pcie_link_pkg::*;

module lane_fifo #(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [LANE_W-1:0] din,
  input  logic              pop,
  output logic [LANE_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              overflow
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [LANE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  // A full lane still accepts a push when the same cycle frees a slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign drop    = push && !do_push;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  // Storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating tally of dropped bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux1x2_8bits.sv
// demux1x2_8bits: splits the interleaved byte stream into two lane FIFOs
// using a free-running selector that toggles every clock.
// Optional feature macro: DEMUX_DROP_CNT_EN (per-lane drop counters).
import pcie_link_pkg::*;

module demux1x2_8bits #(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned START_LANE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop0,
  input  logic              pop1,
  output logic [LANE_W-1:0] data_out0,
  output logic [LANE_W-1:0] data_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              full0,
  output logic              full1,
  output logic              overflow0,
  output logic              overflow1
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt0,
  output logic [DROP_W-1:0] drop_cnt1
`endif
);

  lane_sel_t selector;
  logic      push0;
  logic      push1;

  // Selector runs free so it stays phase-locked to the transmitter.
  always_ff @(posedge clk) begin
    if (reset) begin
      selector <= lane_sel_t'(START_LANE);
    end else begin
      selector <= ~selector;
    end
  end

  assign push0 = valid_in && (selector == lane_sel_t'(0));
  assign push1 = valid_in && (selector == lane_sel_t'(1));

  lane_fifo #(.DEPTH(DEPTH)) u_lane0 (
    .clk      (clk),
    .reset    (reset),
    .push     (push0),
    .din      (data_in),
    .pop      (pop0),
    .dout     (data_out0),
    .valid    (valid_out0),
    .full     (full0),
    .overflow (overflow0)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt0)
`endif
  );

  lane_fifo #(.DEPTH(DEPTH)) u_lane1 (
    .clk      (clk),
    .reset    (reset),
    .push     (push1),
    .din      (data_in),
    .pop      (pop1),
    .dout     (data_out1),
    .valid    (valid_out1),
    .full     (full1),
    .overflow (overflow1)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt1)
`endif
  );

endmodule

// File: tb/tb_demux1x2_8bits.sv
// Scoreboard bench for demux1x2_8bits (DEPTH=4, START_LANE=0).
module tb_demux1x2_8bits;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       pop0;
  logic       pop1;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic       valid_out0;
  logic       valid_out1;
  logic       full0;
  logic       full1;
  logic       overflow0;
  logic       overflow1;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt0;
  logic [7:0] drop_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  demux1x2_8bits #(.DEPTH(4), .START_LANE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .pop0       (pop0),
    .pop1       (pop1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .full0      (full0),
    .full1      (full1),
    .overflow0  (overflow0),
    .overflow1  (overflow1)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt0  (drop_cnt0),
    .drop_cnt1  (drop_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; returns at posedge+1.
  task automatic cyc(input logic [7:0] d, input logic v, input logic p0, input logic p1);
    data_in  = d;
    valid_in = v;
    pop0     = p0;
    pop1     = p1;
    @(posedge clk);
    #1;
  endtask

  // Reset with junk inputs that must be ignored.
  task automatic do_reset();
    q0.delete();
    q1.delete();
    reset = 1'b1;
    cyc(8'h77, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    data_in = 8'h00; valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
  endtask

  // Monitor: every popped head must match the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (pop0 && valid_out0) begin
        if (q0.size() == 0) chk("lane0_unexpected", 32'(data_out0), 32'hFFFF_FFFF);
        else chk("lane0_data", 32'(data_out0), 32'(q0.pop_front()));
      end
      if (pop1 && valid_out1) begin
        if (q1.size() == 0) chk("lane1_unexpected", 32'(data_out1), 32'hFFFF_FFFF);
        else chk("lane1_data", 32'(data_out1), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; data_in = 8'h00; valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
    #2;

    // T1: interleave A0..A3.
    do_reset();
    chk("rst_valid0", 32'(valid_out0), 32'd0);
    chk("rst_valid1", 32'(valid_out1), 32'd0);
    chk("rst_full0", 32'(full0), 32'd0);
    chk("rst_ovf0", 32'(overflow0), 32'd0);
    chk("rst_dout0", 32'(data_out0), 32'h00);
    chk("rst_dout1", 32'(data_out1), 32'h00);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst_dcnt0", 32'(drop_cnt0), 32'd0);
`endif
    q0.push_back(8'hA0); q0.push_back(8'hA2);
    q1.push_back(8'hA1); q1.push_back(8'hA3);
    cyc(8'hA0, 1'b1, 1'b0, 1'b0);
    chk("t1_valid0_rise", 32'(valid_out0), 32'd1);
    chk("t1_valid1_low", 32'(valid_out1), 32'd0);
    cyc(8'hA1, 1'b1, 1'b0, 1'b0);
    chk("t1_valid1_rise", 32'(valid_out1), 32'd1);
    cyc(8'hA2, 1'b1, 1'b0, 1'b0);
    cyc(8'hA3, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1, 1'b1);
    chk("t1_drained0", 32'(valid_out0), 32'd0);
    chk("t1_drained1", 32'(valid_out1), 32'd0);

    // T2: valid only on even cycles -> lane 0 only.
    do_reset();
    q0.push_back(8'hB0); q0.push_back(8'hB2); q0.push_back(8'hB4);
    for (int i = 0; i < 6; i++) cyc(8'hB0 + 8'(i), ((i % 2) == 0), 1'b0, 1'b0);
    chk("t2_lane1_empty", 32'(valid_out1), 32'd0);
    chk("t2_lane0_head", 32'(data_out0), 32'hB0);
    for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("t2_drained0", 32'(valid_out0), 32'd0);

    // T3: five bytes into lane 0, the fifth is dropped.
    do_reset();
    q0.push_back(8'hC0); q0.push_back(8'hC1); q0.push_back(8'hC2); q0.push_back(8'hC3);
    for (int i = 0; i < 10; i++) begin
      cyc(8'hC0 + 8'(i / 2), ((i % 2) == 0), 1'b0, 1'b0);
      if (i == 6) begin
        chk("t3_full_after4", 32'(full0), 32'd1);
        chk("t3_no_ovf_yet", 32'(overflow0), 32'd0);
      end
    end
    chk("t3_ovf0", 32'(overflow0), 32'd1);
    chk("t3_full0", 32'(full0), 32'd1);
    chk("t3_head", 32'(data_out0), 32'hC0);
    chk("t3_ovf1_clear", 32'(overflow1), 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("t3_dcnt0", 32'(drop_cnt0), 32'd1);
    chk("t3_dcnt1", 32'(drop_cnt1), 32'd0);
`endif
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_drained0", 32'(valid_out0), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow0), 32'd1);

    // T4: full lane, push and pop together.
    do_reset();
    q0.push_back(8'hC0); q0.push_back(8'hC1); q0.push_back(8'hC2); q0.push_back(8'hC3);
    for (int i = 0; i < 8; i++) cyc(8'hC0 + 8'(i / 2), ((i % 2) == 0), 1'b0, 1'b0);
    chk("t4_full_before", 32'(full0), 32'd1);
    q0.push_back(8'hD0);
    cyc(8'hD0, 1'b1, 1'b1, 1'b0);
    chk("t4_full_kept", 32'(full0), 32'd1);
    chk("t4_no_ovf", 32'(overflow0), 32'd0);
    chk("t4_head_adv", 32'(data_out0), 32'hC1);
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("t4_drained0", 32'(valid_out0), 32'd0);

    // T5: pop on empty lane 1, then push 5C.
    do_reset();
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("t5_empty_valid1", 32'(valid_out1), 32'd0);
    chk("t5_empty_full1", 32'(full1), 32'd0);
    chk("t5_empty_ovf1", 32'(overflow1), 32'd0);
    q1.push_back(8'h5C);
    cyc(8'h5C, 1'b1, 1'b0, 1'b0);
    chk("t5_valid1", 32'(valid_out1), 32'd1);
    chk("t5_dout1", 32'(data_out1), 32'h5C);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("t5_drained1", 32'(valid_out1), 32'd0);

    // T6: reset mid-stream with three entries per lane.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(8'hF0 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("t6_valid0", 32'(valid_out0), 32'd1);
    chk("t6_valid1", 32'(valid_out1), 32'd1);
    chk("t6_not_full", 32'(full0), 32'd0);
    do_reset();
    chk("t6_rst_valid0", 32'(valid_out0), 32'd0);
    chk("t6_rst_valid1", 32'(valid_out1), 32'd0);
    chk("t6_rst_full1", 32'(full1), 32'd0);
    chk("t6_rst_ovf0", 32'(overflow0), 32'd0);
    chk("t6_rst_ovf1", 32'(overflow1), 32'd0);
    q0.push_back(8'hE0);
    cyc(8'hE0, 1'b1, 1'b0, 1'b0);
    chk("t6_start_lane0", 32'(valid_out0), 32'd1);
    chk("t6_start_lane1", 32'(valid_out1), 32'd0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);

    chk("sb_q0_empty", 32'(q0.size()), 32'd0);
    chk("sb_q1_empty", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
